// File: rtl/llc_req_in_buffer_pkg.sv
// LLC request input buffer: shared types and constants.
// Line address split, entry bundle and stalled-register states.
package llc_req_in_buffer_pkg;

  localparam int LINE_ADDR_BITS    = 26;
  localparam int LLC_SET_BITS      = 8;
  localparam int LLC_TAG_BITS      = LINE_ADDR_BITS - LLC_SET_BITS;
  localparam int LLC_REQ_BUF_DEPTH = 2;
  localparam int LLC_REQ_INFO_W    = 64;

  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [LLC_SET_BITS-1:0]   llc_set_t;
  typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;

  typedef struct packed {
    line_addr_t                addr;
    logic [LLC_REQ_INFO_W-1:0] info;
  } llc_req_buf_entry_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } stall_state_t;

  function automatic llc_set_t addr_set(line_addr_t a);
    return a[LLC_SET_BITS-1:0];
  endfunction

  function automatic llc_tag_t addr_tag(line_addr_t a);
    return a[LINE_ADDR_BITS-1:LLC_SET_BITS];
  endfunction

endpackage

// File: rtl/llc_req_in_buffer_if.sv
// L2 -> LLC request channel handshake.
// master drives the request, slave returns ready.
interface llc_req_in_buffer_if
  import llc_req_in_buffer_pkg::*;
#(
  parameter int INFO_W = LLC_REQ_INFO_W
);

  logic              llc_req_in_valid;
  logic              llc_req_in_ready;
  line_addr_t        llc_req_in_addr;
  logic [INFO_W-1:0] llc_req_in_info;

  modport master (
    output llc_req_in_valid,
    output llc_req_in_addr,
    output llc_req_in_info,
    input  llc_req_in_ready
  );

  modport slave (
    input  llc_req_in_valid,
    input  llc_req_in_addr,
    input  llc_req_in_info,
    output llc_req_in_ready
  );

endinterface

// File: rtl/llc_req_in_buffer_fifo.sv
// Generic storage FIFO for llc_req_in_buffer.
// Overflowing pushes and underflowing pops are dropped.
module llc_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] usage,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] usage_q, usage_d;
  logic             do_push, do_pop;

  assign full    = (usage_q == CNT_W'(DEPTH));
  assign empty   = (usage_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign usage   = usage_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   usage_d = usage_q + CNT_W'(1);
      2'b01:   usage_d = usage_q - CNT_W'(1);
      default: usage_d = usage_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

endmodule

// File: rtl/llc_req_in_buffer.sv
// LLC request input buffer: FIFO, current and stalled request registers.
// Define LLC_REQ_BUF_BYPASS_EN for flow-through when the FIFO is empty.
module llc_req_in_buffer
  import llc_req_in_buffer_pkg::*;
#(
  parameter int DEPTH  = LLC_REQ_BUF_DEPTH,
  parameter int INFO_W = LLC_REQ_INFO_W
) (
  input  logic                   clk,
  input  logic                   rst,
  llc_req_in_buffer_if.slave     req_in,
  output logic                   llc_req_in_valid_int,
  output line_addr_t             req_in_addr,
  input  logic                   do_get_req,
  input  logic                   update_req_in_from_stalled,
  input  logic                   clr_req_in_stalled_valid,
  input  logic                   set_req_in_stalled,
  output line_addr_t             req_cur_addr,
  output logic [INFO_W-1:0]      req_cur_info,
  output logic                   req_in_stalled_valid,
  output llc_set_t               req_in_stalled_set,
  output llc_tag_t               req_in_stalled_tag,
  output logic [$clog2(DEPTH):0] usage
);

  typedef struct packed {
    line_addr_t        addr;
    logic [INFO_W-1:0] info;
  } entry_t;

  entry_t       in_entry, head;
  entry_t       cur_q, cur_d;
  entry_t       stall_q, stall_d;
  stall_state_t st_q, st_d;
  logic         fifo_full, fifo_empty;
  logic         fifo_push, fifo_pop;
  logic         bypass_take;

  assign in_entry = '{addr: req_in.llc_req_in_addr,
                      info: req_in.llc_req_in_info};

`ifdef LLC_REQ_BUF_BYPASS_EN
  assign bypass_take = fifo_empty
                    && req_in.llc_req_in_valid
                    && do_get_req
                    && !update_req_in_from_stalled;
  assign llc_req_in_valid_int =
    fifo_empty ? req_in.llc_req_in_valid : 1'b1;
  assign req_in_addr =
    fifo_empty ? req_in.llc_req_in_addr : head.addr;
`else
  assign bypass_take          = 1'b0;
  assign llc_req_in_valid_int = !fifo_empty;
  assign req_in_addr          = head.addr;
`endif

  assign req_in.llc_req_in_ready = !fifo_full;

  // A stalled replay wins the cycle, so the FIFO head stays put.
  assign fifo_push = req_in.llc_req_in_valid && !fifo_full
                  && !bypass_take;
  assign fifo_pop  = do_get_req && !update_req_in_from_stalled
                  && !fifo_empty;

  llc_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .usage (usage),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    cur_d = cur_q;
    unique case (1'b1)
      update_req_in_from_stalled: cur_d = stall_q;
      fifo_pop:                   cur_d = head;
      bypass_take:                cur_d = in_entry;
      default:                    cur_d = cur_q;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    st_d    = st_q;
    if (set_req_in_stalled) begin
      stall_d = cur_q;
      st_d    = ST_HELD;
    end else if (clr_req_in_stalled_valid) begin
      st_d    = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= '0;
      stall_q <= '0;
      st_q    <= ST_EMPTY;
    end else begin
      cur_q   <= cur_d;
      stall_q <= stall_d;
      st_q    <= st_d;
    end
  end

  assign req_cur_addr         = cur_q.addr;
  assign req_cur_info         = cur_q.info;
  assign req_in_stalled_valid = (st_q == ST_HELD);
  assign req_in_stalled_set   = addr_set(stall_q.addr);
  assign req_in_stalled_tag   = addr_tag(stall_q.addr);

  a_get_nonempty: assert property (
    @(posedge clk) disable iff (rst)
    !(do_get_req && !update_req_in_from_stalled
      && fifo_empty && !bypass_take)
  ) else $warning("llc_req_in_buffer: do_get_req with empty buffer");

endmodule

// File: tb/tb_llc_req_in_buffer.sv
// Directed bench for llc_req_in_buffer.
// Stimulus queues expectations; a negedge monitor retires them.
module tb_llc_req_in_buffer;
  import llc_req_in_buffer_pkg::*;

  typedef enum {
    F_VINT, F_ADDR, F_RDY, F_USE,
    F_CADDR, F_CINFO, F_SV, F_SSET, F_STAG
  } fld_t;

  typedef struct {
    string       name;
    int          due;
    fld_t        f;
    logic [63:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vint;
  line_addr_t head_addr;
  logic       get, upd, clr, set;
  line_addr_t cur_addr;
  logic [63:0] cur_info;
  logic       st_valid;
  llc_set_t   st_set;
  llc_tag_t   st_tag;
  logic [1:0] usage;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  llc_req_in_buffer_if #(.INFO_W(64)) req_if ();

  llc_req_in_buffer #(.DEPTH(2), .INFO_W(64)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .req_in                     (req_if),
    .llc_req_in_valid_int       (vint),
    .req_in_addr                (head_addr),
    .do_get_req                 (get),
    .update_req_in_from_stalled (upd),
    .clr_req_in_stalled_valid   (clr),
    .set_req_in_stalled         (set),
    .req_cur_addr               (cur_addr),
    .req_cur_info               (cur_info),
    .req_in_stalled_valid       (st_valid),
    .req_in_stalled_set         (st_set),
    .req_in_stalled_tag         (st_tag),
    .usage                      (usage)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sample(fld_t f);
    case (f)
      F_VINT:  return 64'(vint);
      F_ADDR:  return 64'(head_addr);
      F_RDY:   return 64'(req_if.llc_req_in_ready);
      F_USE:   return 64'(usage);
      F_CADDR: return 64'(cur_addr);
      F_CINFO: return cur_info;
      F_SV:    return 64'(st_valid);
      F_SSET:  return 64'(st_set);
      F_STAG:  return 64'(st_tag);
      default: return 64'hx;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [63:0] act;
        act = sample(sb[i].f);
        compared++;
        if (act !== sb[i].v) begin
          mismatched++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                   sb[i].name, act, sb[i].v, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic drive(input logic r, input logic v,
                       input logic [25:0] a, input logic [63:0] inf,
                       input logic g, input logic u,
                       input logic c, input logic s);
    @(posedge clk);
    #2;
    rst                     = r;
    req_if.llc_req_in_valid = v;
    req_if.llc_req_in_addr  = a;
    req_if.llc_req_in_info  = inf;
    get = g;
    upd = u;
    clr = c;
    set = s;
  endtask

  task automatic ex(input string n, input fld_t f,
                    input logic [63:0] v, input int d);
    exp_t e;
    e.name = n;
    e.due  = cyc + d;
    e.f    = f;
    e.v    = v;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    req_if.llc_req_in_valid = 1'b0;
    req_if.llc_req_in_addr  = '0;
    req_if.llc_req_in_info  = '0;
    get = 0; upd = 0; clr = 0; set = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    ex("rst_usage", F_USE, 0, 1);
    ex("rst_vint", F_VINT, 0, 1);
    ex("rst_ready", F_RDY, 1, 1);
    ex("rst_stv", F_SV, 0, 1);
    ex("rst_cur", F_CADDR, 0, 1);

    drive(0, 1, 26'h1234, 64'h11, 0, 0, 0, 0);
    ex("push1_ready", F_RDY, 1, 0);
`ifdef LLC_REQ_BUF_BYPASS_EN
    ex("push1_vint_now", F_VINT, 1, 0);
`else
    ex("push1_vint_now", F_VINT, 0, 0);
`endif
    ex("push1_vint", F_VINT, 1, 1);
    ex("push1_addr", F_ADDR, 64'h1234, 1);
    ex("push1_usage", F_USE, 1, 1);

    drive(0, 1, 26'h88, 64'h22, 0, 0, 0, 0);
    ex("push2_usage", F_USE, 2, 1);
    ex("push2_ready", F_RDY, 0, 1);
    ex("push2_head", F_ADDR, 64'h1234, 1);

    drive(0, 1, 26'h77, 64'h33, 0, 0, 0, 0);
    ex("full_ready", F_RDY, 0, 0);
    ex("full_usage", F_USE, 2, 1);
    ex("full_head", F_ADDR, 64'h1234, 1);

    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ex("pop1_cur", F_CADDR, 64'h1234, 1);
    ex("pop1_info", F_CINFO, 64'h11, 1);
    ex("pop1_usage", F_USE, 1, 1);
    ex("pop1_head", F_ADDR, 64'h88, 1);
    ex("pop1_ready", F_RDY, 1, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 1);
    ex("set_stv", F_SV, 1, 1);
    ex("set_set", F_SSET, 64'h34, 1);
    ex("set_tag", F_STAG, 64'h12, 1);

    drive(0, 1, 26'h55, 64'h44, 0, 0, 0, 0);
    ex("push3_ready", F_RDY, 1, 0);
    ex("push3_usage", F_USE, 2, 1);

    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ex("pop2_cur", F_CADDR, 64'h88, 1);
    ex("pop2_head", F_ADDR, 64'h55, 1);
    ex("pop2_usage", F_USE, 1, 1);

    drive(0, 0, 0, 0, 1, 1, 0, 0);
    ex("upd_cur", F_CADDR, 64'h1234, 1);
    ex("upd_info", F_CINFO, 64'h11, 1);
    ex("upd_head", F_ADDR, 64'h55, 1);
    ex("upd_usage", F_USE, 1, 1);

    drive(0, 0, 0, 0, 0, 0, 1, 1);
    ex("setclr_stv", F_SV, 1, 1);

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    ex("clr_stv", F_SV, 0, 1);
    ex("clr_set_kept", F_SSET, 64'h34, 1);
    ex("clr_tag_kept", F_STAG, 64'h12, 1);

    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ex("pop3_cur", F_CADDR, 64'h55, 1);
    ex("pop3_usage", F_USE, 0, 1);
    ex("pop3_vint", F_VINT, 0, 1);

    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ex("empty_get_cur", F_CADDR, 64'h55, 1);
    ex("empty_get_info", F_CINFO, 64'h44, 1);
    ex("empty_get_usage", F_USE, 0, 1);
    ex("empty_get_vint", F_VINT, 0, 1);

    drive(0, 1, 26'hA1, 64'hA1, 0, 0, 0, 0);
    drive(0, 1, 26'hA2, 64'hA2, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    ex("prerst_usage", F_USE, 2, 1);
    ex("prerst_stv", F_SV, 1, 1);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    ex("rst2_usage", F_USE, 0, 1);
    ex("rst2_ready", F_RDY, 1, 1);
    ex("rst2_vint", F_VINT, 0, 1);
    ex("rst2_stv", F_SV, 0, 1);
    ex("rst2_cur", F_CADDR, 0, 1);
    ex("rst2_info", F_CINFO, 0, 1);
    ex("rst2_set", F_SSET, 0, 1);
    ex("rst2_tag", F_STAG, 0, 1);

    drive(0, 1, 26'hABC, 64'h5, 1, 0, 0, 0);
`ifdef LLC_REQ_BUF_BYPASS_EN
    ex("byp_vint_now", F_VINT, 1, 0);
    ex("byp_addr_now", F_ADDR, 64'hABC, 0);
    ex("byp_cur", F_CADDR, 64'hABC, 1);
    ex("byp_info", F_CINFO, 64'h5, 1);
    ex("byp_usage", F_USE, 0, 1);
`else
    ex("nobyp_vint_now", F_VINT, 0, 0);
    ex("nobyp_usage", F_USE, 1, 1);
    ex("nobyp_cur", F_CADDR, 0, 1);
    ex("nobyp_head", F_ADDR, 64'hABC, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ex("nobyp_pop_cur", F_CADDR, 64'hABC, 1);
    ex("nobyp_pop_info", F_CINFO, 64'h5, 1);
    ex("nobyp_pop_usage", F_USE, 0, 1);
`endif

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched += sb.size();
      $display("FAIL leftover: %0d expectations not retired, 0 required",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
